my_dmux_16_4_way_stream: RTL and testbench
==========================================

# my_dmux_16_4_way_stream

Registered 16-bit 1-to-4 demultiplexer with a valid/ready handshake on every port. It takes words from one upstream source and steers each word to output channel a, b, c or d according to `sel` sampled with the word. Each channel has a one-entry holding register, so a stalled channel never blocks the other three. It sits at the fan-out end of the 4-way 16-bit mux path.

## Interface
- `WIDTH`, 16, data word width.
- `clk`  input  1  system clock; all state changes on the rising edge.
- `rst_n`  input  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `in`  input  WIDTH  upstream data word.
- `sel`  input  2  destination of `in`: 00→a, 01→b, 10→c, 11→d.
- `in_valid`  input  1  `in` and `sel` are valid.
- `in_ready`  output  1  block accepts the word this cycle.
- `a`, `b`, `c`, `d`  output  WIDTH each  channel data; each driven directly from its holding register.
- `a_valid`, `b_valid`, `c_valid`, `d_valid`  output  1 each  channel register holds an undelivered word.
- `a_ready`, `b_ready`, `c_ready`, `d_ready`  input  1 each  downstream accepts the channel word.
- `cnt`  output  32  only with `MY_DMUX_STATS_EN`: packed delivery counters {d, c, b, a}, 8 bits each.

## Operation
- Per channel x, the block holds `data_x[WIDTH-1:0]` and `full_x`.
- `x_valid = full_x`; output `x = data_x`.
- Accept: `in_ready = !full[sel] || ready[sel]`. This is combinational in `sel`, `in_valid`-independent, and the ready of the selected channel only.
- Transfer in: when `in_valid && in_ready`, `data[sel] <= in` and `full[sel] <= 1`.
- Drain: when `full_x && x_ready` and no transfer in targets x, `full_x <= 0`.
- Simultaneous drain and fill of the same channel: `full_x` stays 1 and `data_x` takes the new word. No bubble, so full throughput is one word per cycle per channel.
- Non-selected channels drain independently in the same cycle.
- `data_x` keeps its last value after draining. Downstream must qualify the data with `x_valid`.
- `sel` is ignored when `in_valid = 0`.
- Upstream rule: once `in_valid` is high, `in` and `sel` must stay stable until accepted. The block does not check this.

## Timing
- Reset (`rst_n = 0` at a rising edge): all `full_x = 0`, all `data_x = 0`, counters = 0.
  - Outputs after reset: `x_valid = 0`, `x = 16'h0000`. `in_ready = 1` for any `sel`.
- Reset mid-operation: buffered words are discarded, with no drain handshake. Reset overrides a same-edge transfer.
- Latency: a word accepted at edge N appears with `x_valid = 1` after edge N, i.e. in cycle N+1.
- Backpressure: with `full_x = 1` and `x_ready = 0`, `in_ready = 0` whenever `sel = x`. `x` and `x_valid` hold steady until `x_ready` rises.
- There is no combinational path from `in` to any `x`. The only combinational path is `x_ready`/`sel` → `in_ready`.

## Configuration
- `MY_DMUX_STATS_EN` defined:
  - Adds four 8-bit counters, each incremented on every drain of its channel (`full_x && x_ready`).
  - Counters wrap 255→0 and are cleared by reset.
  - Counters are exposed on `cnt`.
- `MY_DMUX_STATS_EN` undefined: the counters and the `cnt` port do not exist. All other behaviour is identical.

## Test plan
- Reset with all readies high, then send `in = 16'h8000`, `sel = 00`; then `16'h0800`/01, `16'h0080`/10, `16'h0008`/11 on consecutive cycles.
  - Each word appears on a/b/c/d respectively one cycle after acceptance, with only that channel's valid high.
  - `in_ready` stays 1 throughout.
- Stall: `a_ready = 0`, send `16'h1234`/00, then `16'h5678`/00.
  - Second word sees `in_ready = 0`; `a` holds `16'h1234`.
  - Raise `a_ready`: `a` delivers `16'h1234`, then `16'h5678` the next cycle.
- Independence: `a_ready = 0` with a full, then send `16'hBEEF`/01 → accepted immediately; `b = 16'hBEEF`, `b_valid = 1`, `a` unchanged.
- Back-to-back same channel with `d_ready = 1`: 8 words `16'h0001`..`16'h0008` on `sel = 11` → one delivery per cycle, in order, no bubbles.
- Reset mid-operation with a, c full and stalled: pulse `rst_n` low one cycle → all valids 0 and all outputs `16'h0000` next cycle; `in_ready = 1`.
- With `MY_DMUX_STATS_EN`: deliver 257 words on channel c → `cnt[23:16] = 1`, other counter fields 0.

Source files
------------

// File: rtl/my_dmux_16_4_way_stream.sv
// Registered 1-to-4 stream demultiplexer with a one-word holding register per channel.
// Define MY_DMUX_STATS_EN to add per-channel 8-bit delivery counters on port cnt.
module my_dmux_16_4_way_stream #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic [1:0]       sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic             a_valid,
    output logic             b_valid,
    output logic             c_valid,
    output logic             d_valid,
    input  logic             a_ready,
    input  logic             b_ready,
    input  logic             c_ready,
    input  logic             d_ready
`ifdef MY_DMUX_STATS_EN
    ,
    output logic [31:0]      cnt
`endif
);

    logic [WIDTH-1:0] data [4];
    logic [3:0]       full;
    logic [3:0]       ready;
    logic [3:0]       fill;

    assign ready = {d_ready, c_ready, b_ready, a_ready};

    // A channel can take a word if it is empty or is being drained this cycle.
    assign in_ready = !full[sel] || ready[sel];

    always_comb begin
        fill      = 4'b0000;
        fill[sel] = in_valid && in_ready;
    end

    // A fill wins over a drain, so a channel streams one word per cycle without bubbles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (fill[i]) begin
                    data[i] <= in;
                    full[i] <= 1'b1;
                end else if (full[i] && ready[i]) begin
                    full[i] <= 1'b0;
                end
            end
        end
    end

    assign a       = data[0];
    assign b       = data[1];
    assign c       = data[2];
    assign d       = data[3];
    assign a_valid = full[0];
    assign b_valid = full[1];
    assign c_valid = full[2];
    assign d_valid = full[3];

`ifdef MY_DMUX_STATS_EN
    logic [7:0] drain_cnt [4];

    // Counts every completed downstream handshake, wrapping at 255.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                drain_cnt[i] <= 8'd0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (full[i] && ready[i]) begin
                    drain_cnt[i] <= drain_cnt[i] + 8'd1;
                end
            end
        end
    end

    assign cnt = {drain_cnt[3], drain_cnt[2], drain_cnt[1], drain_cnt[0]};
`endif

endmodule

// File: tb/tb_my_dmux_16_4_way_stream.sv
// Self-checking bench for my_dmux_16_4_way_stream: directed vector table, streaming and
// reset sequences, and a randomized run against a channel-buffer model (MY_DMUX_STATS_EN aware).
module tb_my_dmux_16_4_way_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] in_word;
    logic [1:0]  sel;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a, b, c, d;
    logic        a_valid, b_valid, c_valid, d_valid;
    logic        a_ready, b_ready, c_ready, d_ready;
`ifdef MY_DMUX_STATS_EN
    logic [31:0] cnt;
`endif

    always #5 clk = ~clk;

    my_dmux_16_4_way_stream #(.WIDTH(16)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in(in_word),
        .sel(sel),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a(a),
        .b(b),
        .c(c),
        .d(d),
        .a_valid(a_valid),
        .b_valid(b_valid),
        .c_valid(c_valid),
        .d_valid(d_valid),
        .a_ready(a_ready),
        .b_ready(b_ready),
        .c_ready(c_ready),
        .d_ready(d_ready)
`ifdef MY_DMUX_STATS_EN
        ,
        .cnt(cnt)
`endif
    );

    typedef struct {
        logic        rst;
        logic        iv;
        logic [1:0]  s;
        logic [15:0] word;
        logic [3:0]  rdy;
        logic        exp_ir;
        logic [3:0]  exp_valid;
        logic [63:0] exp_data;
    } vec_t;

    vec_t vecs [16];

    int checks = 0;
    int errors = 0;

    // Each channel is modelled as a one-slot buffer: a word sitting in it, and whether it is taken.
    logic [15:0] m_data [4];
    logic [3:0]  m_full;
    logic [7:0]  m_cnt [4];
    logic        model_ok = 1'b0;

    function automatic logic [3:0] cur_ready();
        return {d_ready, c_ready, b_ready, a_ready};
    endfunction

    function automatic logic model_in_ready();
        logic [3:0] r;
        r = cur_ready();
        return !m_full[sel] || r[sel];
    endfunction

    task automatic applyStimulus(input logic r, input logic iv, input logic [1:0] s,
                                 input logic [15:0] w, input logic [3:0] rdy);
        rst_n    = r;
        in_valid = iv;
        sel      = s;
        in_word  = w;
        {d_ready, c_ready, b_ready, a_ready} = rdy;
    endtask

    task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        checkValue("in_ready", 64'(in_ready), 64'(model_in_ready()));
        checkValue("valids", 64'({d_valid, c_valid, b_valid, a_valid}), 64'(m_full));
        checkValue("a", 64'(a), 64'(m_data[0]));
        checkValue("b", 64'(b), 64'(m_data[1]));
        checkValue("c", 64'(c), 64'(m_data[2]));
        checkValue("d", 64'(d), 64'(m_data[3]));
`ifdef MY_DMUX_STATS_EN
        checkValue("cnt", 64'(cnt), 64'({m_cnt[3], m_cnt[2], m_cnt[1], m_cnt[0]}));
`endif
    endtask

    task automatic modelUpdate();
        logic [3:0] r;
        logic       take;
        r    = cur_ready();
        take = in_valid && model_in_ready();
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                m_data[i] = 16'h0000;
                m_cnt[i]  = 8'd0;
            end
            m_full   = 4'b0000;
            model_ok = 1'b1;
        end else if (model_ok) begin
            for (int i = 0; i < 4; i++) begin
                if (m_full[i] && r[i]) begin
                    m_cnt[i]  = m_cnt[i] + 8'd1;
                    m_full[i] = 1'b0;
                end
                if (take && sel == 2'(i)) begin
                    m_data[i] = in_word;
                    m_full[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic preEdge();
        #1;
        if (model_ok) checkOutput();
    endtask

    task automatic clockEdge();
        @(posedge clk);
        modelUpdate();
        @(negedge clk);
    endtask

    initial begin
        logic pending;

        // Directed vectors: inputs, in_ready before the edge, valids/data {d,c,b,a} after it.
        vecs[0]  = '{1'b1, 1'b1, 2'd0, 16'h8000, 4'hF, 1'b1, 4'b0001, 64'h0000_0000_0000_8000};
        vecs[1]  = '{1'b1, 1'b1, 2'd1, 16'h0800, 4'hF, 1'b1, 4'b0010, 64'h0000_0000_0800_8000};
        vecs[2]  = '{1'b1, 1'b1, 2'd2, 16'h0080, 4'hF, 1'b1, 4'b0100, 64'h0000_0080_0800_8000};
        vecs[3]  = '{1'b1, 1'b1, 2'd3, 16'h0008, 4'hF, 1'b1, 4'b1000, 64'h0008_0080_0800_8000};
        vecs[4]  = '{1'b1, 1'b0, 2'd0, 16'h0000, 4'hF, 1'b1, 4'b0000, 64'h0008_0080_0800_8000};
        vecs[5]  = '{1'b1, 1'b1, 2'd0, 16'h1234, 4'hE, 1'b1, 4'b0001, 64'h0008_0080_0800_1234};
        vecs[6]  = '{1'b1, 1'b1, 2'd0, 16'h5678, 4'hE, 1'b0, 4'b0001, 64'h0008_0080_0800_1234};
        vecs[7]  = '{1'b1, 1'b1, 2'd0, 16'h5678, 4'hF, 1'b1, 4'b0001, 64'h0008_0080_0800_5678};
        vecs[8]  = '{1'b1, 1'b0, 2'd0, 16'h0000, 4'hF, 1'b1, 4'b0000, 64'h0008_0080_0800_5678};
        vecs[9]  = '{1'b1, 1'b1, 2'd0, 16'h0A0A, 4'hE, 1'b1, 4'b0001, 64'h0008_0080_0800_0A0A};
        vecs[10] = '{1'b1, 1'b1, 2'd1, 16'hBEEF, 4'hE, 1'b1, 4'b0011, 64'h0008_0080_BEEF_0A0A};
        vecs[11] = '{1'b1, 1'b0, 2'd0, 16'h0000, 4'hF, 1'b1, 4'b0000, 64'h0008_0080_BEEF_0A0A};
        vecs[12] = '{1'b1, 1'b1, 2'd0, 16'hAAAA, 4'hA, 1'b1, 4'b0001, 64'h0008_0080_BEEF_AAAA};
        vecs[13] = '{1'b1, 1'b1, 2'd2, 16'hCCCC, 4'hA, 1'b1, 4'b0101, 64'h0008_CCCC_BEEF_AAAA};
        vecs[14] = '{1'b0, 1'b1, 2'd1, 16'h1357, 4'hA, 1'b1, 4'b0000, 64'h0000_0000_0000_0000};
        vecs[15] = '{1'b1, 1'b0, 2'd2, 16'h0000, 4'h0, 1'b1, 4'b0000, 64'h0000_0000_0000_0000};

        m_full = 4'b0000;
        applyStimulus(1'b0, 1'b0, 2'd0, 16'h0000, 4'hF);
        clockEdge();
        clockEdge();

        // Reset state for every destination
        for (int s = 0; s < 4; s++) begin
            applyStimulus(1'b1, 1'b0, 2'(s), 16'h0000, 4'hF);
            #1;
            checkValue("reset_in_ready", 64'(in_ready), 64'd1);
        end
        checkValue("reset_valids", 64'({d_valid, c_valid, b_valid, a_valid}), 64'd0);
        checkValue("reset_data", {d, c, b, a}, 64'd0);

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].iv, vecs[i].s, vecs[i].word, vecs[i].rdy);
            preEdge();
            checkValue($sformatf("tbl%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].exp_ir));
            clockEdge();
            checkValue($sformatf("tbl%0d_valids", i),
                       64'({d_valid, c_valid, b_valid, a_valid}), 64'(vecs[i].exp_valid));
            checkValue($sformatf("tbl%0d_data", i), {d, c, b, a}, vecs[i].exp_data);
        end

        // Back-to-back stream into d: one delivery per cycle, in order
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(1'b1, 1'b1, 2'd3, 16'(k), 4'hF);
            preEdge();
            checkValue("b2b_in_ready", 64'(in_ready), 64'd1);
            clockEdge();
            checkValue("b2b_d_valid", 64'(d_valid), 64'd1);
            checkValue("b2b_d", 64'(d), 64'(k));
        end
        applyStimulus(1'b1, 1'b0, 2'd3, 16'h0000, 4'hF);
        preEdge();
        clockEdge();
        checkValue("b2b_drained", 64'(d_valid), 64'd0);

`ifdef MY_DMUX_STATS_EN
        applyStimulus(1'b0, 1'b0, 2'd0, 16'h0000, 4'hF);
        clockEdge();
        for (int k = 0; k < 257; k++) begin
            applyStimulus(1'b1, 1'b1, 2'd2, 16'(k), 4'hF);
            preEdge();
            clockEdge();
        end
        applyStimulus(1'b1, 1'b0, 2'd0, 16'h0000, 4'hF);
        preEdge();
        clockEdge();
        checkValue("stats_cnt", 64'(cnt), 64'h0000_0000_0001_0000);
`endif

        // Randomized traffic; a stalled word is held stable until accepted
        pending = 1'b0;
        for (int n = 0; n < 400; n++) begin
            logic [3:0] rdy;
            for (int j = 0; j < 4; j++) rdy[j] = ($urandom_range(0, 3) != 0);
            if (pending) begin
                applyStimulus(1'b1, 1'b1, sel, in_word, rdy);
            end else begin
                applyStimulus(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) < 7),
                              2'($urandom_range(0, 3)), 16'($urandom), rdy);
            end
            preEdge();
            pending = rst_n && in_valid && !model_in_ready();
            clockEdge();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
